pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the performance counters.
REQ-002 cpu_clk_75M  input  1  sole clock; all state updates on its rising edge.
REQ-003 cpu_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stallreq_if  input  1  IF stage stall request (fetch miss).
REQ-005 stallreq_id  input  1  ID stage stall request (load-use).
REQ-006 stallreq_exe  input  1  EXE stage stall request (multi-cycle mul/div).
REQ-007 stallreq_mem  input  1  MEM stage stall request (data access busy).
REQ-008 excp_req  input  1  exception detected at MEM stage; sampled with excp_vector.
REQ-009 excp_vector  input  32  handler address for excp_req.
REQ-010 eret_req  input  1  ERET at MEM stage; sampled with epc.
REQ-011 epc  input  32  return address for eret_req.
REQ-012 perf_clr  input  1  synchronous clear of the performance counters.
REQ-013 stall  output  6  bit0 PC, 1 IF, 2 ID, 3 EXE, 4 MEM, 5 WB; 1 = Stop.
REQ-014 flush  output  1  registered, one-cycle pipeline flush to all stage registers.
REQ-015 new_pc  output  32  registered redirect target; valid while flush=1.
REQ-016 perf_stall_cnt  output  CNT_W  stall-cycle count.
REQ-017 perf_flush_cnt  output  CNT_W  flush-event count.

Function
REQ-018 stall is combinational; the highest requesting stage wins: mem -> 6'b011111, else exe -> 6'b001111, else id -> 6'b000111, else if -> 6'b000011, else 6'b000000.
REQ-019 The FSM has three states, RUN, PEND and FLUSH.
REQ-020 RUN, with excp_req or eret_req and stallreq_mem=0: load new_pc and go to FLUSH at the next edge.
REQ-021 RUN, with excp_req or eret_req and stallreq_mem=1: load new_pc and go to PEND.
REQ-022 RUN, with neither request: stay in RUN.
REQ-023 When excp_req and eret_req are both 1 in the same cycle, excp_req wins and new_pc = excp_vector; otherwise new_pc = epc for eret_req.
REQ-024 PEND: new_pc holds; new excp_req/eret_req are ignored (the first event wins); go to FLUSH on the first edge with stallreq_mem=0.
REQ-025 FLUSH: flush=1 for exactly one cycle, stall forced to 6'b000000, all requests ignored, then unconditional return to RUN.
REQ-026 flush=1 only in FLUSH; flush to new_pc latency is one cycle after the accepting edge.
REQ-027 new_pc holds its last value outside a load.
REQ-028 Back-to-back events: an excp_req presented in the cycle after FLUSH is accepted normally from RUN.

Reset
REQ-029 On cpu_rst_n=0, immediately and independently of the clock: state=RUN, flush=0, new_pc=32'h0, counters=0.
REQ-030 Reset during PEND or FLUSH abandons the pending redirect; no flush pulse follows reset release.
REQ-031 While cpu_rst_n=0, stall still follows REQ-018 combinationally; stage registers ignore it under reset.

Configuration
REQ-032 Macro PIPE_CTRL_PERF_CNT_EN controls the performance counters.
REQ-033 With PIPE_CTRL_PERF_CNT_EN defined, perf_stall_cnt increments each cycle stall[0]=1, and perf_flush_cnt increments on each entry into FLUSH.
REQ-034 With PIPE_CTRL_PERF_CNT_EN defined, both counters saturate at all-ones, and perf_clr=1 zeroes both at the next edge, taking priority over increment.
REQ-035 Without PIPE_CTRL_PERF_CNT_EN, perf_stall_cnt and perf_flush_cnt are tied to 0, no counter registers exist, and perf_clr is ignored.

Verification
REQ-036 stallreq_id=1 and stallreq_mem=1 together -> stall=6'b011111; only stallreq_if=1 -> stall=6'b000011.
REQ-037 excp_req=1, excp_vector=32'hBFC00380, stallreq_mem=0 at edge N -> flush=1 and new_pc=32'hBFC00380 in cycle N+1 only; flush=0 at N+2.
REQ-038 eret_req=1 with epc=32'h80001000 while stallreq_mem=1 for 3 cycles, plus excp_req during PEND -> flush pulses once, the cycle after stallreq_mem falls, with new_pc=32'h80001000.
REQ-039 excp_req and eret_req in the same cycle with excp_vector=32'h80000180 -> new_pc=32'h80000180; during FLUSH with stallreq_exe=1 -> stall=0.
REQ-040 cpu_rst_n pulsed low mid-PEND -> flush=0 and new_pc=0 immediately; no flush after release.
REQ-041 With PIPE_CTRL_PERF_CNT_EN: 5 stalled cycles plus 2 flushes -> perf_stall_cnt=5, perf_flush_cnt=2; perf_clr -> both 0. Without the macro -> both always 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall priority, exception/ERET redirect FSM and optional
// performance counters (enabled with `define PIPE_CTRL_PERF_CNT_EN).
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             cpu_clk_75M,
    input  logic             cpu_rst_n,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_exe,
    input  logic             stallreq_mem,
    input  logic             excp_req,
    input  logic [31:0]      excp_vector,
    input  logic             eret_req,
    input  logic [31:0]      epc,
    input  logic             perf_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    logic   redirect_req;
    logic   flush_enter;

    assign redirect_req = excp_req | eret_req;
    assign flush_enter  = ((state == RUN) && redirect_req && !stallreq_mem) ||
                          ((state == PEND) && !stallreq_mem);

    // Deepest stalled stage wins; FLUSH overrides every request.
    always_comb begin
        stall = '0;
        if (state != FLUSH) begin
            if (stallreq_mem)      stall = 6'b011111;
            else if (stallreq_exe) stall = 6'b001111;
            else if (stallreq_id)  stall = 6'b000111;
            else if (stallreq_if)  stall = 6'b000011;
        end
    end

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state  <= RUN;
            flush  <= 1'b0;
            new_pc <= '0;
        end else begin
            case (state)
                RUN: begin
                    flush <= 1'b0;
                    if (redirect_req) begin
                        new_pc <= excp_req ? excp_vector : epc;
                        if (stallreq_mem) begin
                            state <= PEND;
                        end else begin
                            state <= FLUSH;
                            flush <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (!stallreq_mem) begin
                        state <= FLUSH;
                        flush <= 1'b1;
                    end
                end
                FLUSH: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
                default: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (perf_clr) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall[0] && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (flush_enter && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf    = perf_clr | flush_enter;
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; counter expectations follow
// whether PIPE_CTRL_PERF_CNT_EN is defined.
module tb_pipe_ctrl;

    localparam int unsigned CW = 4;

    logic          cpu_clk_75M = 1'b0;
    logic          cpu_rst_n;
    logic          stallreq_if, stallreq_id, stallreq_exe, stallreq_mem;
    logic          excp_req, eret_req, perf_clr;
    logic [31:0]   excp_vector, epc;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   new_pc;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;

    int unsigned total  = 0;
    int unsigned passed = 0;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .cpu_clk_75M   (cpu_clk_75M),
        .cpu_rst_n     (cpu_rst_n),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_exe  (stallreq_exe),
        .stallreq_mem  (stallreq_mem),
        .excp_req      (excp_req),
        .excp_vector   (excp_vector),
        .eret_req      (eret_req),
        .epc           (epc),
        .perf_clr      (perf_clr),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 cpu_clk_75M = ~cpu_clk_75M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge cpu_clk_75M);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_sc, exp_fc, exp_sat;
        cpu_rst_n = 1'b0;
        {stallreq_if, stallreq_id, stallreq_exe, stallreq_mem} = '0;
        {excp_req, eret_req, perf_clr} = '0;
        excp_vector = '0;
        epc = '0;
        #2;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        chk("rst_stall", {26'd0, stall}, 32'd0);
        stallreq_exe = 1'b1; #1;
        chk("rst_stall_exe", {26'd0, stall}, 32'h0F);
        stallreq_exe = 1'b0;
        tick();
        cpu_rst_n = 1'b1;
        tick();

        // Stall priority
        stallreq_id = 1'b1; stallreq_mem = 1'b1; #1;
        chk("stall_id_mem", {26'd0, stall}, 32'h1F);
        stallreq_mem = 1'b0; #1;
        chk("stall_id", {26'd0, stall}, 32'h07);
        stallreq_id = 1'b0; stallreq_exe = 1'b1; stallreq_if = 1'b1; #1;
        chk("stall_exe_if", {26'd0, stall}, 32'h0F);
        stallreq_exe = 1'b0; #1;
        chk("stall_if", {26'd0, stall}, 32'h03);
        stallreq_if = 1'b0; #1;
        chk("stall_none", {26'd0, stall}, 32'h00);

        // Exception with no MEM stall
        excp_req = 1'b1; excp_vector = 32'hBFC00380;
        tick();
        excp_req = 1'b0; excp_vector = 32'h0;
        chk("excp_flush", {31'd0, flush}, 32'd1);
        chk("excp_new_pc", new_pc, 32'hBFC00380);
        tick();
        chk("excp_flush_end", {31'd0, flush}, 32'd0);
        chk("excp_pc_hold", new_pc, 32'hBFC00380);

        // ERET held off by MEM stall; later exception ignored
        eret_req = 1'b1; epc = 32'h80001000; stallreq_mem = 1'b1;
        tick();
        eret_req = 1'b0; epc = 32'h0;
        excp_req = 1'b1; excp_vector = 32'h12345678;
        chk("pend_flush0", {31'd0, flush}, 32'd0);
        chk("pend_stall", {26'd0, stall}, 32'h1F);
        tick();
        chk("pend_flush1", {31'd0, flush}, 32'd0);
        tick();
        chk("pend_flush2", {31'd0, flush}, 32'd0);
        stallreq_mem = 1'b0; excp_req = 1'b0;
        tick();
        chk("pend_flush", {31'd0, flush}, 32'd1);
        chk("pend_new_pc", new_pc, 32'h80001000);
        tick();
        chk("pend_flush_end", {31'd0, flush}, 32'd0);

        // Simultaneous excp/eret, FLUSH stall override, back-to-back event
        excp_req = 1'b1; eret_req = 1'b1; excp_vector = 32'h80000180; epc = 32'h11111110;
        tick();
        excp_req = 1'b0; eret_req = 1'b1; epc = 32'hDEAD0000; stallreq_exe = 1'b1; #1;
        chk("both_flush", {31'd0, flush}, 32'd1);
        chk("both_new_pc", new_pc, 32'h80000180);
        chk("flush_stall", {26'd0, stall}, 32'h00);
        tick();
        eret_req = 1'b0;
        chk("flush_ignored", new_pc, 32'h80000180);
        chk("flush_end", {31'd0, flush}, 32'd0);
        chk("run_stall_exe", {26'd0, stall}, 32'h0F);
        stallreq_exe = 1'b0; excp_req = 1'b1; excp_vector = 32'h80000200;
        tick();
        excp_req = 1'b0;
        chk("b2b_flush", {31'd0, flush}, 32'd1);
        chk("b2b_new_pc", new_pc, 32'h80000200);
        tick();
        chk("b2b_flush_end", {31'd0, flush}, 32'd0);

        // Reset during PEND
        eret_req = 1'b1; epc = 32'h80002000; stallreq_mem = 1'b1;
        tick();
        eret_req = 1'b0;
        chk("rp_new_pc", new_pc, 32'h80002000);
        #2 cpu_rst_n = 1'b0; #1;
        chk("rp_flush", {31'd0, flush}, 32'd0);
        chk("rp_new_pc0", new_pc, 32'd0);
        stallreq_mem = 1'b0;
        tick();
        cpu_rst_n = 1'b1;
        tick();
        chk("rp_noflush1", {31'd0, flush}, 32'd0);
        tick();
        chk("rp_noflush2", {31'd0, flush}, 32'd0);

        // Performance counters
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        chk("perf_clr_s", {28'd0, perf_stall_cnt}, 32'd0);
        chk("perf_clr_f", {28'd0, perf_flush_cnt}, 32'd0);
        stallreq_if = 1'b1;
        repeat (5) tick();
        stallreq_if = 1'b0;
        repeat (2) begin
            excp_req = 1'b1; excp_vector = 32'h80000180;
            tick();
            excp_req = 1'b0;
            tick();
        end
`ifdef PIPE_CTRL_PERF_CNT_EN
        exp_sc = 32'd5; exp_fc = 32'd2; exp_sat = 32'd15;
`else
        exp_sc = 32'd0; exp_fc = 32'd0; exp_sat = 32'd0;
`endif
        chk("perf_stall", {28'd0, perf_stall_cnt}, exp_sc);
        chk("perf_flush", {28'd0, perf_flush_cnt}, exp_fc);
        stallreq_if = 1'b1;
        repeat (20) tick();
        chk("perf_sat", {28'd0, perf_stall_cnt}, exp_sat);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0; stallreq_if = 1'b0;
        chk("perf_clr2_s", {28'd0, perf_stall_cnt}, 32'd0);
        chk("perf_clr2_f", {28'd0, perf_flush_cnt}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
